// File: rtl/ysyx_22041412_pkg.sv
// Shared constants for the writeback arbiter: requester indices and default widths.
package ysyx_22041412_pkg;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_idx_e;

    localparam int WB_DW = 64;
    localparam int WB_AW = 5;

endpackage

// File: rtl/ysyx_22041412_reg_arn.sv
// Plain D register with active-low asynchronous reset to a parameterised value.
module ysyx_22041412_reg_arn #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_o <= RESET_VAL;
        else         q_o <= d_i;
    end

endmodule

// File: rtl/ysyx_22041412_wb_arb.sv
// Two-requester round-robin register-file writeback arbiter with a registered write port.
// Optional forwarding port enabled by YSYX_22041412_WB_BYPASS_EN.
module ysyx_22041412_wb_arb
    import ysyx_22041412_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
`ifdef YSYX_22041412_WB_BYPASS_EN
    input  logic [AW-1:0] byp_raddr,
    output logic          byp_hit,
    output logic [DW-1:0] byp_data,
`endif
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          busy
);

    logic [1:0]    vld, gnt;
    logic          ptr_q, ptr_d;
    logic          any_gnt;
    logic [AW-1:0] gnt_addr, waddr_d;
    logic [DW-1:0] gnt_data, wdata_d;
    logic          wen_d;

    assign vld[REQ_EXU] = req0_valid;
    assign vld[REQ_LSU] = req1_valid;

    // Grants are gated by reset so both ready outputs drop without a clock edge.
    always_comb begin
        gnt = '0;
        if (rst) begin
            if (vld[REQ_EXU] && (!vld[REQ_LSU] || ptr_q == REQ_EXU))
                gnt[REQ_EXU] = 1'b1;
            else if (vld[REQ_LSU])
                gnt[REQ_LSU] = 1'b1;
        end
    end

    assign req0_ready = gnt[REQ_EXU];
    assign req1_ready = gnt[REQ_LSU];
    assign busy       = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);
    assign any_gnt    = |gnt;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[REQ_EXU])      ptr_d = REQ_LSU;
        else if (gnt[REQ_LSU]) ptr_d = REQ_EXU;
    end

    assign gnt_addr = gnt[REQ_LSU] ? req1_addr : req0_addr;
    assign gnt_data = gnt[REQ_LSU] ? req1_data : req0_data;

    // x0 writes are accepted and latched but never enable the register file.
    assign wen_d   = any_gnt & (gnt_addr != '0);
    assign waddr_d = any_gnt ? gnt_addr : rf_waddr;
    assign wdata_d = any_gnt ? gnt_data : rf_wdata;

    ysyx_22041412_reg_arn #(.WIDTH(1), .RESET_VAL(1'b0)) u_ptr (
        .clk_i(clk), .rst_ni(rst), .d_i(ptr_d), .q_o(ptr_q)
    );

    ysyx_22041412_reg_arn #(.WIDTH(1), .RESET_VAL(1'b0)) u_wen (
        .clk_i(clk), .rst_ni(rst), .d_i(wen_d), .q_o(rf_wen)
    );

    ysyx_22041412_reg_arn #(.WIDTH(AW), .RESET_VAL('0)) u_waddr (
        .clk_i(clk), .rst_ni(rst), .d_i(waddr_d), .q_o(rf_waddr)
    );

    ysyx_22041412_reg_arn #(.WIDTH(DW), .RESET_VAL('0)) u_wdata (
        .clk_i(clk), .rst_ni(rst), .d_i(wdata_d), .q_o(rf_wdata)
    );

`ifdef YSYX_22041412_WB_BYPASS_EN
    assign byp_hit  = rf_wen & (rf_waddr == byp_raddr) & (byp_raddr != '0);
    assign byp_data = rf_wdata;
`endif

endmodule

// File: tb/tb_ysyx_22041412_wb_arb.sv
// Directed self-checking bench for the writeback arbiter.
module tb_ysyx_22041412_wb_arb;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;
`ifdef YSYX_22041412_WB_BYPASS_EN
    logic [AW-1:0] byp_raddr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22041412_wb_arb #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
`ifdef YSYX_22041412_WB_BYPASS_EN
        .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle();
        req0_addr = '0; req0_data = '0;
        req1_addr = '0; req1_data = '0;
`ifdef YSYX_22041412_WB_BYPASS_EN
        byp_raddr = '0;
`endif
        #3;
        chk("rst_wen",   rf_wen,   0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);

        // single requester held through reset, granted once reset drops
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h1234;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_busy",   busy,       1);
        tick(); #3;
        rst = 1'b1;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        chk("single_busy",   busy,       0);
        tick();
        chk("single_wen",   rf_wen,   1);
        chk("single_waddr", rf_waddr, 5);
        chk("single_wdata", rf_wdata, 64'h1234);
        idle();
        tick();
        chk("idle_wen",   rf_wen,   0);
        chk("idle_waddr", rf_waddr, 5);
        chk("idle_wdata", rf_wdata, 64'h1234);

        // contention from a fresh reset
        #1 rst = 1'b0;
        #1;
        chk("rst2_waddr", rf_waddr, 0);
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h22;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont%0d_ready0", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("cont%0d_ready1", i), req1_ready, (i % 2 == 0) ? 0 : 1);
            chk($sformatf("cont%0d_busy", i),   busy,       1);
            tick();
            chk($sformatf("cont%0d_wen", i),   rf_wen,   1);
            chk($sformatf("cont%0d_waddr", i), rf_waddr, (i % 2 == 0) ? 1 : 2);
            chk($sformatf("cont%0d_wdata", i), rf_wdata, (i % 2 == 0) ? 64'h11 : 64'h22);
        end

        // x0 write from req1: accepted, no enable
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'hFFFF;
        #1;
        chk("x0_ready1", req1_ready, 1);
        chk("x0_ready0", req0_ready, 0);
        chk("x0_busy",   busy,       0);
        tick();
        chk("x0_wen",   rf_wen,   0);
        chk("x0_wdata", rf_wdata, 64'hFFFF);

        // req1 granted, 3 idle cycles, then contention -> req0 first
        req1_addr = 5'd9; req1_data = 64'h99;
        tick();
        chk("hold1_wen",   rf_wen,   1);
        chk("hold1_waddr", rf_waddr, 9);
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("hold1_idle_wen",   rf_wen,   0);
        chk("hold1_idle_waddr", rf_waddr, 9);
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 64'h44;
        req1_valid = 1'b1;
        #1;
        chk("hold1_ready0", req0_ready, 1);
        chk("hold1_ready1", req1_ready, 0);
        tick();
        chk("hold1_waddr2", rf_waddr, 4);

        // req0 was last granted; after idle, contention favours req1
        idle();
        tick(); tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("hold0_ready0", req0_ready, 0);
        chk("hold0_ready1", req1_ready, 1);
        tick();
        chk("hold0_wen",   rf_wen,   1);
        chk("hold0_waddr", rf_waddr, 9);

        // reset during an offered transfer
        req1_valid = 1'b0;
        req0_addr = 5'd3; req0_data = 64'h33;
        #1;
        chk("midrst_pre_ready0", req0_ready, 1);
        rst = 1'b0;
        #1;
        chk("midrst_wen",    rf_wen,     0);
        chk("midrst_waddr",  rf_waddr,   0);
        chk("midrst_wdata",  rf_wdata,   0);
        chk("midrst_ready0", req0_ready, 0);
        chk("midrst_ready1", req1_ready, 0);
        tick();
        chk("midrst_edge_wen", rf_wen, 0);
        idle();
        #1 rst = 1'b1;
        tick();
        chk("midrst_post_wen1", rf_wen, 0);
        tick();
        chk("midrst_post_wen2", rf_wen, 0);

`ifdef YSYX_22041412_WB_BYPASS_EN
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'hAB;
        tick();
        idle();
        byp_raddr = 5'd7;
        #1;
        chk("byp_hit",  byp_hit,  1);
        chk("byp_data", byp_data, 64'hAB);
        byp_raddr = 5'd0;
        #1;
        chk("byp_x0_hit", byp_hit, 0);
        byp_raddr = 5'd7;
        tick();
        chk("byp_nowen_hit", byp_hit, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
